itcm_dump: RTL and testbench

- Readback engine for the 64-bit-wide instruction SRAM; the opposite direction of the byte-wise ITCM image load.
- On `start`, reads a range of ITCM words through the SRAM read port and serialises each word into bytes, least significant byte first. Byte order matches the `.verilog` image layout: byte address i maps to `mem[i/8][8*(i%8)+7 : 8*(i%8)]`.
- Streams bytes out over a valid/ready interface and keeps a running checksum.
- Used by benches and debug logic to dump or verify ITCM contents after boot.

---
 rtl/itcm_pkg.sv | 23 ++
 rtl/itcm_dump_word_serializer.sv | 55 +++++
 rtl/itcm_dump.sv | 134 +++++++++++++
 tb/tb_itcm_dump.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/itcm_pkg.sv
// itcm_pkg: constants and types shared by the ITCM image loader and the
// ITCM readback (dump) engine.
//   ITCM_SIZE      - ITCM size in bytes
//   ITCM_DW        - SRAM word width in bits
//   ITCM_AW        - SRAM word address width
//   BYTES_PER_WORD - byte lanes per SRAM word
//   dump_state_e   - readback engine FSM states
package itcm_pkg;

  localparam int ITCM_SIZE      = 16384;
  localparam int ITCM_DW        = 64;
  localparam int ITCM_AW        = 11;
  localparam int BYTES_PER_WORD = 8;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    SHIFT,
    FIN
  } dump_state_e;

endpackage

// File: rtl/itcm_dump_word_serializer.sv
// word_serializer: loads one SRAM word and presents it as bytes, least
// significant byte first, over a valid/ready handshake.
//   clk      - system clock
//   rst      - synchronous active-high reset
//   i_load   - capture i_word and restart at byte 0
//   i_word   - SRAM word to serialise
//   i_active - byte stream enabled (drives o_valid)
//   i_ready  - downstream accepts the current byte
//   o_valid  - current byte valid
//   o_data   - current byte
//   o_last   - current byte is the top lane of the word
//   o_xfer   - a byte transfers at this edge
module word_serializer
  import itcm_pkg::*;
#(
  parameter int DW = ITCM_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic [DW-1:0] i_word,
  input  logic          i_active,
  input  logic          i_ready,
  output logic          o_valid,
  output logic [7:0]    o_data,
  output logic          o_last,
  output logic          o_xfer
);

  logic [DW-1:0] r_shreg;
  logic [2:0]    r_idx;
  logic          w_xfer;

  assign w_xfer  = i_active & i_ready;
  assign o_valid = i_active;
  assign o_data  = r_shreg[7:0];
  assign o_last  = (r_idx == 3'(BYTES_PER_WORD - 1));
  assign o_xfer  = w_xfer;

  // The shift register is cleared on reset so byte_data reads 0 afterwards;
  // it only moves on a transfer, which keeps the byte stable under stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shreg <= '0;
      r_idx   <= '0;
    end else if (i_load) begin
      r_shreg <= i_word;
      r_idx   <= '0;
    end else if (w_xfer) begin
      r_shreg <= r_shreg >> 8;
      r_idx   <= r_idx + 3'd1;
    end
  end

endmodule

// File: rtl/itcm_dump.sv
// itcm_dump: reads a range of ITCM words through the SRAM read port and
// streams them out byte by byte (LSB first, matching .verilog image byte
// order) with a running modulo-2^32 checksum.
//   clk, cpurst            - clock, synchronous active-high reset
//   start                  - launch pulse, honoured only when idle
//   start_addr, word_count - first word index and number of words (0 legal)
//   busy, done             - dump in progress / one-cycle completion pulse
//   sram_cs, sram_addr     - SRAM read request
//   sram_rdata             - SRAM read data, one cycle after sram_cs
//   byte_valid, byte_data,
//   byte_last, byte_ready  - byte stream handshake, byte_last on final byte
//   checksum               - sum of bytes transferred since the last start
module itcm_dump
  import itcm_pkg::*;
#(
  parameter int ITCM_SIZE = itcm_pkg::ITCM_SIZE,
  parameter int DW        = itcm_pkg::ITCM_DW,
  parameter int AW        = itcm_pkg::ITCM_AW
) (
  input  logic          clk,
  input  logic          cpurst,
  input  logic          start,
  input  logic [AW-1:0] start_addr,
  input  logic [AW:0]   word_count,
  output logic          busy,
  output logic          done,
  output logic          sram_cs,
  output logic [AW-1:0] sram_addr,
  input  logic [DW-1:0] sram_rdata,
  output logic          byte_valid,
  output logic [7:0]    byte_data,
  output logic          byte_last,
  input  logic          byte_ready,
  output logic [31:0]   checksum
);

  localparam int WORDS = ITCM_SIZE / BYTES_PER_WORD;

  dump_state_e   r_state;
  dump_state_e   w_next;
  logic [AW-1:0] r_addr;
  logic [AW:0]   r_remain;
  logic [31:0]   r_checksum;

  logic          w_valid;
  logic [7:0]    w_data;
  logic          w_lane_last;
  logic          w_xfer;
  logic          w_word_done;
  logic          w_final_word;

  word_serializer #(.DW(DW)) u_ser (
    .clk      (clk),
    .rst      (cpurst),
    .i_load   (r_state == RD_WAIT),
    .i_word   (sram_rdata),
    .i_active (r_state == SHIFT),
    .i_ready  (byte_ready),
    .o_valid  (w_valid),
    .o_data   (w_data),
    .o_last   (w_lane_last),
    .o_xfer   (w_xfer)
  );

  assign w_word_done  = w_xfer & w_lane_last;
  assign w_final_word = (r_remain == (AW+1)'(1));

  always_comb begin
    w_next     = r_state;
    busy       = 1'b0;
    done       = 1'b0;
    sram_cs    = 1'b0;
    byte_valid = 1'b0;
    byte_last  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next = (word_count == '0) ? FIN : RD_REQ;
        end
      end
      RD_REQ: begin
        busy    = 1'b1;
        sram_cs = 1'b1;
        w_next  = RD_WAIT;
      end
      RD_WAIT: begin
        busy   = 1'b1;
        w_next = SHIFT;
      end
      SHIFT: begin
        busy       = 1'b1;
        byte_valid = w_valid;
        byte_last  = w_valid & w_lane_last & w_final_word;
        if (w_word_done) begin
          w_next = w_final_word ? FIN : RD_REQ;
        end
      end
      FIN: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (cpurst) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_remain   <= '0;
      r_checksum <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && start) begin
        r_addr     <= start_addr;
        r_remain   <= word_count;
        r_checksum <= '0;
      end
      if (w_xfer) begin
        r_checksum <= r_checksum + {24'd0, w_data};
      end
      // Address wraps at the top of the ITCM.
      if (w_word_done) begin
        r_addr   <= (r_addr == AW'(WORDS - 1)) ? '0 : r_addr + AW'(1);
        r_remain <= r_remain - (AW+1)'(1);
      end
    end
  end

  assign sram_addr = r_addr;
  assign byte_data = w_data;
  assign checksum  = r_checksum;

endmodule

// File: tb/tb_itcm_dump.sv
module tb_itcm_dump;

  logic        clk = 1'b0;
  logic        cpurst;
  logic        start;
  logic [10:0] start_addr;
  logic [11:0] word_count;
  logic        busy;
  logic        done;
  logic        sram_cs;
  logic [10:0] sram_addr;
  logic [63:0] sram_rdata;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_last;
  logic        byte_ready;
  logic [31:0] checksum;

  logic [63:0] mem [0:2047];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  itcm_dump dut (
    .clk        (clk),
    .cpurst     (cpurst),
    .start      (start),
    .start_addr (start_addr),
    .word_count (word_count),
    .busy       (busy),
    .done       (done),
    .sram_cs    (sram_cs),
    .sram_addr  (sram_addr),
    .sram_rdata (sram_rdata),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_last  (byte_last),
    .byte_ready (byte_ready),
    .checksum   (checksum)
  );

  // SRAM model: data appears one cycle after the read request; junk otherwise.
  always @(posedge clk) begin
    if (sram_cs) sram_rdata <= mem[sram_addr];
    else         sram_rdata <= {$urandom, $urandom};
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // mode: 0 ready always high, 1 ready pattern 1,0,0, 2 random ready.
  // poke_n: cycle at which a competing start is issued (0 = never).
  // rst_n : cycle at which cpurst is pulsed (0 = never).
  task automatic do_dump(input logic [10:0] sa, input int wc, input int mode,
                         input int poke_n, input int rst_n);
    logic [7:0]  exp_q[$];
    logic [31:0] exp_sum;
    logic [63:0] w;
    logic [10:0] ea;
    logic [7:0]  prev_data;
    bit          prev_stall;
    bit          finished;
    int          idx;
    int          cs_cnt;
    int          budget;
    exp_q      = {};
    exp_sum    = 0;
    for (int i = 0; i < wc; i++) begin
      w = mem[(int'(sa) + i) % 2048];
      for (int b = 0; b < 8; b++) begin
        exp_q.push_back(w[8*b +: 8]);
        exp_sum = exp_sum + 32'(w[8*b +: 8]);
      end
    end
    idx        = 0;
    cs_cnt     = 0;
    prev_stall = 0;
    prev_data  = 0;
    finished   = 0;
    budget     = 400 * wc + 20;

    @(negedge clk);
    start      = 1'b1;
    start_addr = sa;
    word_count = 12'(wc);
    byte_ready = 1'b1;

    for (int n = 1; n <= budget; n++) begin
      @(negedge clk);
      start  = (n == poke_n);
      if (n == poke_n) begin
        start_addr = sa ^ 11'h155;
        word_count = 12'(wc + 1);
      end
      cpurst = (n == rst_n);
      case (mode)
        0:       byte_ready = 1'b1;
        1:       byte_ready = (n % 3 == 1);
        default: byte_ready = ($urandom_range(0, 3) != 0);
      endcase

      if (rst_n != 0 && n == rst_n + 1) begin
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cs", sram_cs, 0);
        chk("rst_valid", byte_valid, 0);
        chk("rst_last", byte_last, 0);
        chk("rst_addr", sram_addr, 0);
        chk("rst_data", byte_data, 0);
        chk("rst_checksum", checksum, 0);
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          chk("rst_no_done", done, 0);
          chk("rst_idle", busy, 0);
        end
        return;
      end

      if (byte_valid) begin
        if (idx >= exp_q.size()) begin
          chk("extra_byte", 1, 0);
        end else begin
          chk("byte_data", byte_data, exp_q[idx]);
          chk("byte_last", byte_last, (idx == exp_q.size() - 1));
          if (mode == 0) chk("byte_time", n, 3 + 10 * (idx / 8) + (idx % 8));
        end
        if (prev_stall) chk("stall_hold", byte_data, prev_data);
        prev_stall = !byte_ready;
        prev_data  = byte_data;
        if (byte_ready && n != rst_n) idx++;
      end else begin
        chk("last_idle", byte_last, 0);
        prev_stall = 0;
      end

      if (sram_cs) begin
        ea = sa + 11'(cs_cnt);
        chk("sram_addr", sram_addr, ea);
        cs_cnt++;
      end

      if (done) begin
        chk("busy_at_done", busy, 0);
        chk("bytes_total", idx, exp_q.size());
        chk("read_count", cs_cnt, wc);
        chk("checksum", checksum, exp_sum);
        if (wc == 0)       chk("done_time_zero", (n == 1 || n == 2), 1);
        else if (mode == 0) chk("done_time", n, 10 * wc + 1);
        finished = 1;
        break;
      end else if (n != rst_n) begin
        chk("busy", busy, 1);
      end
    end

    if (!finished) begin
      chk("done_timeout", 0, 1);
    end else begin
      @(negedge clk);
      chk("done_pulse", done, 0);
      chk("idle_busy", busy, 0);
      chk("checksum_hold", checksum, exp_sum);
    end
  endtask

  initial begin
    cpurst     = 1'b1;
    start      = 1'b0;
    start_addr = '0;
    word_count = '0;
    byte_ready = 1'b0;
    for (int i = 0; i < 2048; i++) mem[i] = {$urandom, $urandom};

    repeat (2) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_cs", sram_cs, 0);
    chk("reset_valid", byte_valid, 0);
    chk("reset_last", byte_last, 0);
    chk("reset_addr", sram_addr, 0);
    chk("reset_data", byte_data, 0);
    chk("reset_checksum", checksum, 0);
    cpurst = 1'b0;

    mem[0] = 64'h0706050403020100;
    do_dump(11'd0, 1, 0, 0, 0);
    do_dump(11'd0, 1, 1, 0, 0);

    mem[2047] = 64'h1111111111111111;
    mem[0]    = 64'h2222222222222222;
    do_dump(11'd2047, 2, 0, 0, 0);

    do_dump(11'd5, 0, 0, 0, 0);

    do_dump(11'd100, 4, 0, 0, 15);
    do_dump(11'd100, 4, 0, 0, 0);

    do_dump(11'd200, 2, 0, 5, 0);

    for (int t = 0; t < 6; t++) begin
      do_dump(11'($urandom_range(0, 2047)), int'($urandom_range(1, 4)), 2, 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
